// File: rtl/mm_spart_resp.sv
// rtl/mm_spart_resp.sv - memory-mapped 8N1 serial port responder at 0xC000-0xC003 (optional SPART_LOOPBACK_EN ties RX to txd)
module mm_spart_resp #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DB_RST     = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        mm_re,
  output logic        txd,
  input  logic        rxd
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- bus decode ----------------
  logic hit, wr_hit;
  logic sel_data, sel_stat, sel_lo, sel_hi;
  logic status_rd;
  logic unused_wdata;

  assign hit       = (addr[15:2] == 14'h3000);
  assign mm_re     = re & hit;
  assign wr_hit    = we & hit;
  assign sel_data  = (addr[1:0] == 2'd0);
  assign sel_stat  = (addr[1:0] == 2'd1);
  assign sel_lo    = (addr[1:0] == 2'd2);
  assign sel_hi    = (addr[1:0] == 2'd3);
  assign status_rd = mm_re & sel_stat;
  assign unused_wdata = &{1'b0, wdata[15:8]};

  // ---------------- divisor ----------------
  logic [15:0] divisor;
  logic [15:0] bit_p, reload, half, half_load;

  // Divisor bytes are written independently; engines only pick up the new value at a bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= DB_RST;
    end else begin
      if (wr_hit && sel_lo) divisor[7:0]  <= wdata[7:0];
      if (wr_hit && sel_hi) divisor[15:8] <= wdata[7:0];
    end
  end

  assign bit_p     = (divisor == 16'd0) ? 16'd1 : divisor;
  assign reload    = bit_p - 16'd1;
  assign half      = bit_p >> 1;
  // Start-bit detection already costs one clock, so the half-period sample is pulled in to stay centred
  assign half_load = (half >= 16'd2) ? (half - 16'd2) : 16'd0;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [3:0]    tx_fcnt;
  logic          tx_push, tx_pop, tx_do_push, tx_do_pop, tx_empty, tx_full;
  logic [7:0]    tx_head;
  logic [3:0]    tx_free;

  assign tx_push    = wr_hit & sel_data;
  assign tx_empty   = (tx_fcnt == 4'd0);
  assign tx_full    = (tx_fcnt == DEPTH_C);
  assign tx_do_pop  = tx_pop & ~tx_empty;
  assign tx_do_push = tx_push & (~tx_full | tx_do_pop);
  assign tx_head    = tx_mem[tx_rp];
  assign tx_free    = DEPTH_C - tx_fcnt;

  // TX FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp   <= '0;
      tx_rp   <= '0;
      tx_fcnt <= 4'd0;
    end else begin
      if (tx_do_push) tx_wp <= tx_wp + 1'b1;
      if (tx_do_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_do_push, tx_do_pop})
        2'b10:   tx_fcnt <= tx_fcnt + 4'd1;
        2'b01:   tx_fcnt <= tx_fcnt - 4'd1;
        default: tx_fcnt <= tx_fcnt;
      endcase
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_do_push) tx_mem[tx_wp] <= wdata[7:0];
  end

  // ---------------- TX engine ----------------
  tx_state_t   tx_state, tx_nstate;
  logic [15:0] tx_tmr, tx_ntmr;
  logic [7:0]  tx_sh, tx_nsh;
  logic [2:0]  tx_bit, tx_nbit;
  logic        tx_txd, tx_ntxd;

  // TX state register; reset forces the line idle straight away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_tmr   <= 16'd0;
      tx_sh    <= 8'h00;
      tx_bit   <= 3'd0;
      tx_txd   <= 1'b1;
    end else begin
      tx_state <= tx_nstate;
      tx_tmr   <= tx_ntmr;
      tx_sh    <= tx_nsh;
      tx_bit   <= tx_nbit;
      tx_txd   <= tx_ntxd;
    end
  end

  // TX next state: txd is registered so the line changes exactly on bit boundaries
  always_comb begin
    tx_nstate = tx_state;
    tx_ntmr   = tx_tmr;
    tx_nsh    = tx_sh;
    tx_nbit   = tx_bit;
    tx_ntxd   = tx_txd;
    tx_pop    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_ntxd = 1'b1;
        if (!tx_empty) begin
          tx_pop    = 1'b1;
          tx_nsh    = tx_head;
          tx_ntmr   = reload;
          tx_ntxd   = 1'b0;
          tx_nstate = TX_START;
        end
      end
      TX_START: begin
        if (tx_tmr == 16'd0) begin
          tx_nstate = TX_DATA;
          tx_ntmr   = reload;
          tx_nbit   = 3'd0;
          tx_ntxd   = tx_sh[0];
        end else begin
          tx_ntmr = tx_tmr - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_tmr == 16'd0) begin
          tx_ntmr = reload;
          if (tx_bit == 3'd7) begin
            tx_nstate = TX_STOP;
            tx_ntxd   = 1'b1;
          end else begin
            tx_nbit = tx_bit + 3'd1;
            tx_nsh  = {1'b0, tx_sh[7:1]};
            tx_ntxd = tx_sh[1];
          end
        end else begin
          tx_ntmr = tx_tmr - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_tmr == 16'd0) begin
          if (!tx_empty) begin
            tx_pop    = 1'b1;
            tx_nsh    = tx_head;
            tx_ntmr   = reload;
            tx_ntxd   = 1'b0;
            tx_nstate = TX_START;
          end else begin
            tx_ntxd   = 1'b1;
            tx_nstate = TX_IDLE;
          end
        end else begin
          tx_ntmr = tx_tmr - 16'd1;
        end
      end
      default: begin
        tx_nstate = TX_IDLE;
        tx_ntxd   = 1'b1;
      end
    endcase
  end

  assign txd = tx_txd;

  // ---------------- RX input ----------------
  logic rx_s1, rx_s2, rx_in;

  // Two-flop synchroniser for the asynchronous rxd pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

`ifdef SPART_LOOPBACK_EN
  logic unused_rx;
  assign rx_in     = tx_txd;
  assign unused_rx = rx_s2;
`else
  assign rx_in = rx_s2;
`endif

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [3:0]    rx_fcnt;
  logic          rx_push, rx_pop, rx_do_push, rx_do_pop, rx_empty, rx_full;
  logic [7:0]    rx_head;
  logic [7:0]    rx_sh, rx_nsh;

  assign rx_pop     = mm_re & sel_data;
  assign rx_empty   = (rx_fcnt == 4'd0);
  assign rx_full    = (rx_fcnt == DEPTH_C);
  assign rx_do_pop  = rx_pop & ~rx_empty;
  assign rx_do_push = rx_push & (~rx_full | rx_do_pop);
  assign rx_head    = rx_mem[rx_rp];

  // RX FIFO pointers and occupancy; a read that drains a full FIFO makes room for a same-edge push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp   <= '0;
      rx_rp   <= '0;
      rx_fcnt <= 4'd0;
    end else begin
      if (rx_do_push) rx_wp <= rx_wp + 1'b1;
      if (rx_do_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_do_push, rx_do_pop})
        2'b10:   rx_fcnt <= rx_fcnt + 4'd1;
        2'b01:   rx_fcnt <= rx_fcnt - 4'd1;
        default: rx_fcnt <= rx_fcnt;
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_do_push) rx_mem[rx_wp] <= rx_sh;
  end

  // ---------------- RX engine ----------------
  rx_state_t   rx_state, rx_nstate;
  logic [15:0] rx_tmr, rx_ntmr;
  logic [2:0]  rx_bit, rx_nbit;
  logic        rx_armed, rx_narmed;
  logic        set_ovr, set_ferr;

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_tmr   <= 16'd0;
      rx_sh    <= 8'h00;
      rx_bit   <= 3'd0;
      rx_armed <= 1'b0;
    end else begin
      rx_state <= rx_nstate;
      rx_tmr   <= rx_ntmr;
      rx_sh    <= rx_nsh;
      rx_bit   <= rx_nbit;
      rx_armed <= rx_narmed;
    end
  end

  // RX next state: a line held low after a bad stop bit must go high before a new frame is accepted
  always_comb begin
    rx_nstate = rx_state;
    rx_ntmr   = rx_tmr;
    rx_nsh    = rx_sh;
    rx_nbit   = rx_bit;
    rx_narmed = rx_armed;
    rx_push   = 1'b0;
    set_ovr   = 1'b0;
    set_ferr  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_in) begin
          rx_narmed = 1'b1;
        end else if (rx_armed) begin
          rx_nstate = RX_START;
          rx_ntmr   = half_load;
        end
      end
      RX_START: begin
        if (rx_tmr == 16'd0) begin
          if (rx_in) begin
            rx_nstate = RX_IDLE;
          end else begin
            rx_nstate = RX_DATA;
            rx_ntmr   = reload;
            rx_nbit   = 3'd0;
          end
        end else begin
          rx_ntmr = rx_tmr - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_tmr == 16'd0) begin
          rx_nsh  = {rx_in, rx_sh[7:1]};
          rx_ntmr = reload;
          if (rx_bit == 3'd7) rx_nstate = RX_STOP;
          else                rx_nbit   = rx_bit + 3'd1;
        end else begin
          rx_ntmr = rx_tmr - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_tmr == 16'd0) begin
          rx_nstate = RX_IDLE;
          rx_narmed = rx_in;
          if (rx_in) begin
            rx_push = 1'b1;
            set_ovr = rx_full & ~rx_do_pop;
          end else begin
            set_ferr = 1'b1;
          end
        end else begin
          rx_ntmr = rx_tmr - 16'd1;
        end
      end
      default: rx_nstate = RX_IDLE;
    endcase
  end

  // ---------------- sticky flags ----------------
  logic ovr, ferr;

  // Sticky error flags; a new error on the same edge as a STATUS read survives the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (set_ovr)        ovr <= 1'b1;
      else if (status_rd) ovr <= 1'b0;
      if (set_ferr)       ferr <= 1'b1;
      else if (status_rd) ferr <= 1'b0;
    end
  end

  // Zero-latency read mux; an empty RX FIFO reads as zero rather than a stale entry
  always_comb begin
    rdata = 16'h0000;
    if (mm_re) begin
      case (addr[1:0])
        2'd0:    rdata = {8'h00, (rx_empty ? 8'h00 : rx_head)};
        2'd1:    rdata = {ovr, ferr, 6'b000000, tx_free, rx_fcnt};
        2'd2:    rdata = {8'h00, divisor[7:0]};
        default: rdata = {8'h00, divisor[15:8]};
      endcase
    end
  end

endmodule

// File: tb/tb_mm_spart_resp.sv
// tb/tb_mm_spart_resp.sv - directed self-checking bench for mm_spart_resp
module tb_mm_spart_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        mm_re;
  logic        txd;
  logic        rxd;
  logic        rxd_drv = 1'b1;
  logic        loop_mode = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [9:0] cap [10];
  logic [7:0] tx_tab [9];
  logic [7:0] rx_tab [9];

  assign rxd = loop_mode ? txd : rxd_drv;

  always #5 clk = ~clk;

  mm_spart_resp #(.FIFO_DEPTH(8), .DB_RST(16'd434)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .re    (re),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .mm_re (mm_re),
    .txd   (txd),
    .rxd   (rxd)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d, output logic m);
    addr = a; re = 1'b1; we = 1'b0;
    #2;
    d = rdata;
    m = mm_re;
    @(posedge clk); #1;
    re = 1'b0; addr = 16'h0000;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1; re = 1'b0;
    @(posedge clk); #1;
    we = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    logic        m;
    bus_rd(a, d, m);
    check_val(tag, {16'h0000, d}, {16'h0000, exp});
  endtask

  // Waits for a start bit then samples txd mid-bit for nfr consecutive frames at divisor 4
  task automatic tx_capture(input int nfr, output logic ok);
    int w;
    w = 0;
    while (txd !== 1'b0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    ok = (txd === 1'b0);
    if (ok) begin
      repeat (2) @(posedge clk);
      #1;
      for (int f = 0; f < nfr; f++) begin
        for (int b = 0; b < 10; b++) begin
          cap[f][b] = txd;
          repeat (4) @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // Drives one 8N1 frame on rxd at 4 clocks per bit
  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd_drv = 1'b0;
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (4) @(posedge clk); #1;
    end
    rxd_drv = stop;
    repeat (4) @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        m;
    logic        ok;
    logic [2:0]  idle_bits;

    tx_tab = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    rx_tab = '{8'h3C, 8'h81, 8'h7E, 8'h00, 8'hFF, 8'h55, 8'hAA, 8'h12, 8'h99};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    bus_rd(16'hC002, d, m);
    check_val("rst_db_lo", {16'h0, d}, 32'h00B2);
    check_val("rst_db_lo_mm_re", {31'h0, m}, 32'h1);
    bus_rd(16'hC003, d, m);
    check_val("rst_db_hi", {16'h0, d}, 32'h0001);
    check_val("rst_db_hi_mm_re", {31'h0, m}, 32'h1);
    check_val("rst_txd", {31'h0, txd}, 32'h1);
    rd_chk("rst_status", 16'hC001, 16'h0080);

    // single frame 0xA5 at divisor 4
    bus_wr(16'hC002, 16'h0004);
    bus_wr(16'hC003, 16'h0000);
    rd_chk("db_hi_after_wr", 16'hC003, 16'h0000);
    bus_wr(16'hC000, 16'h00A5);
    tx_capture(1, ok);
    check_val("a5_start_seen", {31'h0, ok}, 32'h1);
    check_val("a5_frame", {22'h0, cap[0]}, {22'h0, 1'b1, 8'hA5, 1'b0});
    repeat (8) @(posedge clk); #1;

    // nine back-to-back bytes plus one dropped while full
    fork
      tx_capture(9, ok);
      begin
        for (int i = 0; i < 9; i++) bus_wr(16'hC000, {8'h00, tx_tab[i]});
        rd_chk("tx_full_status", 16'hC001, 16'h0000);
        bus_wr(16'hC000, 16'h00EE);
      end
    join
    check_val("b2b_start_seen", {31'h0, ok}, 32'h1);
    for (int f = 0; f < 9; f++)
      check_val($sformatf("b2b_frame%0d", f), {22'h0, cap[f]}, {22'h0, 1'b1, tx_tab[f], 1'b0});
    for (int k = 0; k < 3; k++) begin
      idle_bits[k] = txd;
      repeat (4) @(posedge clk); #1;
    end
    check_val("b2b_dropped_idle", {29'h0, idle_bits}, 32'h7);
    rd_chk("tx_drained_status", 16'hC001, 16'h0080);

    // external loopback through the rxd pin
    loop_mode = 1'b1;
    bus_wr(16'hC000, 16'h005A);
    repeat (48) @(posedge clk); #1;
    rd_chk("lb_status", 16'hC001, 16'h0081);
    addr = 16'hC000; re = 1'b0;
    #2;
    check_val("nore_mm_re", {31'h0, mm_re}, 32'h0);
    check_val("nore_rdata", {16'h0, rdata}, 32'h0);
    @(posedge clk); #1;
    bus_rd(16'hC004, d, m);
    check_val("c004_mm_re", {31'h0, m}, 32'h0);
    check_val("c004_rdata", {16'h0, d}, 32'h0);
    rd_chk("lb_no_pop_status", 16'hC001, 16'h0081);
    rd_chk("lb_data", 16'hC000, 16'h005A);
    rd_chk("lb_popped_status", 16'hC001, 16'h0080);
    bus_rd(16'hC000, d, m);
    check_val("empty_data", {16'h0, d}, 32'h0);
    check_val("empty_data_mm_re", {31'h0, m}, 32'h1);
    rd_chk("empty_no_pop_status", 16'hC001, 16'h0080);
    loop_mode = 1'b0;
    repeat (4) @(posedge clk); #1;

    // nine received frames without reads: overrun
    for (int i = 0; i < 9; i++) send_rx(rx_tab[i], 1'b1);
    repeat (4) @(posedge clk); #1;
    rd_chk("ovr_status", 16'hC001, 16'h8088);
    rd_chk("ovr_cleared", 16'hC001, 16'h0088);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("rx_data%0d", i), 16'hC000, {8'h00, rx_tab[i]});
    rd_chk("rx_drained_status", 16'hC001, 16'h0080);

    // framing error: line held low through the stop bit
    send_rx(8'h5A, 1'b0);
    repeat (20) @(posedge clk); #1;
    rxd_drv = 1'b1;
    repeat (8) @(posedge clk); #1;
    rd_chk("ferr_status", 16'hC001, 16'h4080);
    rd_chk("ferr_cleared", 16'hC001, 16'h0080);

    // read and write on the same access
    addr = 16'hC002; wdata = 16'h0007; re = 1'b1; we = 1'b1;
    #2;
    check_val("rw_pre_write", {16'h0, rdata}, 32'h0004);
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0; addr = 16'h0000;
    rd_chk("rw_post_write", 16'hC002, 16'h0007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
